// File: rtl/event_stretcher.sv
// event_stretcher: stretches each din rising edge into a HIGH_CYCLES-long dout pulse followed by a GAP_CYCLES low gap.
//
// Ports:
//   clk_1M   - 1 MHz system clock, all logic on its rising edge
//   rst      - synchronous active-low reset
//   din      - event request (level or pulse); each rising edge is one event
//   dout     - stretched pulse, high only in the HIGH state
//   busy     - high whenever the state is not IDLE
//   pending  - number of queued events not yet replayed
//   overflow - sticky flag, set when an event is lost
//
// Optional feature: define EVENT_STRETCHER_QUEUE_EN to queue events arriving
// while busy (up to 15). Without it, such events are dropped and flagged.
module event_stretcher #(
    parameter logic [21:0] HIGH_CYCLES = 22'd100_000,
    parameter logic [21:0] GAP_CYCLES  = 22'd50_000
) (
    input  logic       clk_1M,
    input  logic       rst,
    input  logic       din,
    output logic       dout,
    output logic       busy,
    output logic [3:0] pending,
    output logic       overflow
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    logic [1:0]  state_q, state_d;
    logic [21:0] cnt_q, cnt_d;
    logic [3:0]  pend_q, pend_d;
    logic        ovf_q, ovf_d;
    logic        din_q;
    logic        ev, gap_end, launch_p, launch_e, queue_ev;
    assign ev       = din & ~din_q;
    assign gap_end  = state_q == GAP && cnt_q == 22'd0;
    assign launch_p = gap_end && pend_q != 4'd0;
    // an event in the last gap cycle with nothing queued relaunches directly
    assign launch_e = gap_end && pend_q == 4'd0 && ev;
    assign queue_ev = ev && state_q != IDLE && !launch_e;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (ev) begin
                state_d = HIGH;
                cnt_d   = HIGH_CYCLES - 22'd1;
            end
            HIGH: if (cnt_q == 22'd0) begin
                state_d = GAP;
                cnt_d   = GAP_CYCLES - 22'd1;
            end else begin
                cnt_d = cnt_q - 22'd1;
            end
            GAP: if (cnt_q != 22'd0) begin
                cnt_d = cnt_q - 22'd1;
            end else if (launch_p || launch_e) begin
                state_d = HIGH;
                cnt_d   = HIGH_CYCLES - 22'd1;
            end else begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
`ifdef EVENT_STRETCHER_QUEUE_EN
    // a queued arrival and a queued launch in the same cycle cancel out
    logic [4:0] sum;
    assign sum    = 5'(pend_q) + 5'(queue_ev) - 5'(launch_p);
    assign pend_d = sum[4] ? 4'd15 : sum[3:0];
    assign ovf_d  = ovf_q | sum[4];
`else
    assign pend_d = 4'd0;
    assign ovf_d  = ovf_q | queue_ev;
`endif
    always_ff @(posedge clk_1M) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 22'd0;
            pend_q  <= 4'd0;
            ovf_q   <= 1'b0;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            din_q   <= din;
        end
    end
    assign dout     = state_q == HIGH;
    assign busy     = state_q != IDLE;
    assign pending  = pend_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_event_stretcher.sv
// tb_event_stretcher: scoreboard bench comparing event_stretcher against a pulse-schedule reference model.
module tb_event_stretcher;
    localparam int H = 4;
    localparam int G = 2;
    logic       clk_1M = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       dout, busy, overflow;
    logic [3:0] pending;
    typedef struct packed {
        logic       dout;
        logic       busy;
        logic [3:0] pend;
        logic       ovf;
    } exp_t;
    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   c = 0;
    // model: start cycle of the current/last pulse window plus a queue count
    int   m_start = -1000;
    int   m_pend = 0;
    logic m_ovf = 1'b0;
    logic m_prev = 1'b0;

    event_stretcher #(.HIGH_CYCLES(22'd4), .GAP_CYCLES(22'd2)) dut (
        .clk_1M(clk_1M), .rst(rst), .din(din), .dout(dout),
        .busy(busy), .pending(pending), .overflow(overflow)
    );

    always #5 clk_1M = ~clk_1M;

    task automatic queue_event();
`ifdef EVENT_STRETCHER_QUEUE_EN
        if (m_pend == 15) m_ovf = 1'b1;
        else m_pend++;
`else
        m_ovf = 1'b1;
`endif
    endtask

    task automatic model_edge();
        exp_t e;
        logic ev;
        logic in_win;
        logic last;
        if (!rst) begin
            m_start = -1000;
            m_pend  = 0;
            m_ovf   = 1'b0;
            m_prev  = 1'b0;
        end else begin
            ev     = din && !m_prev;
            m_prev = din;
            in_win = c >= m_start && c < m_start + H + G;
            last   = c == m_start + H + G - 1;
            if (!in_win) begin
                if (ev) m_start = c + 1;
            end else if (last && m_pend > 0) begin
                m_start = c + 1;
                m_pend--;
                if (ev) queue_event();
            end else if (last && ev) begin
                m_start = c + 1;
            end else if (ev) begin
                queue_event();
            end
        end
        e.dout = (c + 1 >= m_start) && (c + 1 < m_start + H);
        e.busy = (c + 1 >= m_start) && (c + 1 < m_start + H + G);
        e.pend = 4'(m_pend);
        e.ovf  = m_ovf;
        q.push_back(e);
        c++;
    endtask

    task automatic step(input logic r, input logic d);
        @(posedge clk_1M);
        model_edge();
        #1;
        rst = r;
        din = d;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, c, act, req);
        end
    endtask

    always @(negedge clk_1M) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("dout", int'(dout), int'(e.dout));
            check("busy", int'(busy), int'(e.busy));
            check("pending", int'(pending), int'(e.pend));
            check("overflow", int'(overflow), int'(e.ovf));
        end
    end

    initial begin
        repeat (3) step(1'b0, 1'b0);
        repeat (9) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (12) step(1'b1, 1'b0);
        repeat (20) step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        repeat (4) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        repeat (30) step(1'b1, 1'b0);
        repeat (20) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        repeat (120) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        repeat (3000) step($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0);
        repeat (200) step(1'b1, 1'b0);
        @(negedge clk_1M);
        @(negedge clk_1M);
        check("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
